// File: rtl/uart_frame_rx_pkg.sv
// Shared definitions for the BTLE debug UART receiver: parity-mode codes,
// receiver state encoding and the baud divider helpers used by both UART ends.
package uart_frame_rx_pkg;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_ODD  = 2'b01;
   localparam logic [1:0] PAR_EVEN = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_t;

   // Whole clocks per bit; truncation matches the transmitter's divider.
   function automatic int calc_bit_div(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

   // Offset from the start edge to the middle of the start bit.
   function automatic int calc_half_div(input int clk_freq, input int baud);
      return calc_bit_div(clk_freq, baud) / 2;
   endfunction

endpackage

// File: rtl/uart_frame_rx_clk_gen.sv
// Receive baud timer: after a restart the first tick comes HALF_DIV clocks
// later (mid start bit), every following tick BIT_DIV clocks apart.
module uart_frame_rx_clk_gen
   import uart_frame_rx_pkg::*;
#(
   parameter int BIT_DIV  = 10,
   parameter int HALF_DIV = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   input  logic run,
   output logic sample_tick
);

   localparam int CNT_W = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 1;
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_DIV - 1);
   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BIT_DIV - 1);

   logic [CNT_W-1:0] cnt;

   assign sample_tick = run && (cnt == '0);

   // Down-counter: terminal count at zero, reload with a full bit period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (restart) begin
         cnt <= HALF_LOAD;
      end else if (run) begin
         cnt <= (cnt == '0) ? FULL_LOAD : cnt - 1'b1;
      end
   end

endmodule

// File: rtl/uart_frame_rx.sv
// UART frame receiver for the BTLE debug/control link. Synchronises the
// line, validates the start bit at mid-bit, assembles an LSB-first frame,
// checks optional parity and the stop bit, and strobes rx_done per frame.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | line idle, waiting for a falling edge on rx_s
//   ST_START  | timing to the middle of the start bit, rejects glitches
//   ST_DATA   | sampling FRAME_WD data bits, first bit ends at LSB
//   ST_PARITY | sampling the parity bit (only when PARITY != "NONE")
//   ST_STOP   | sampling the stop bit, publishing frame and error flags
module uart_frame_rx
   import uart_frame_rx_pkg::*;
#(
   parameter int    CLK_FREQUENCE = 50_000_000,
   parameter int    BAUD_RATE     = 9600,
   parameter string PARITY        = "NONE",
   parameter int    FRAME_WD      = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                uart_rx,
   output logic [FRAME_WD-1:0] data_frame,
   output logic                rx_done,
   output logic                parity_err,
   output logic                frame_err
);

   localparam int BIT_DIV  = calc_bit_div(CLK_FREQUENCE, BAUD_RATE);
   localparam int HALF_DIV = calc_half_div(CLK_FREQUENCE, BAUD_RATE);
   localparam logic [1:0] PAR_MODE = (PARITY == "EVEN") ? PAR_EVEN :
                                     (PARITY == "ODD")  ? PAR_ODD  : PAR_NONE;
   localparam int BIT_CW = (FRAME_WD > 1) ? $clog2(FRAME_WD) : 1;
   localparam logic [BIT_CW-1:0] LAST_BIT = BIT_CW'(FRAME_WD - 1);

   logic rx_meta;
   logic rx_s;
   logic rx_d;
   logic rx_fall;
   logic sample_tick;
   logic restart;
   logic run;

   rx_state_t           state;
   logic [FRAME_WD-1:0] shift_reg;
   logic [BIT_CW-1:0]   bit_cnt;
   logic                par_bad;

   // Two-flop synchroniser plus one delay stage for edge detection; idle high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_d    <= 1'b1;
      end else begin
         rx_meta <= uart_rx;
         rx_s    <= rx_meta;
         rx_d    <= rx_s;
      end
   end

   assign rx_fall = rx_d & ~rx_s;
   assign restart = (state == ST_IDLE) && rx_fall;
   assign run     = (state != ST_IDLE);

   uart_frame_rx_clk_gen #(
      .BIT_DIV  (BIT_DIV),
      .HALF_DIV (HALF_DIV)
   ) u_clk_gen (
      .clk         (clk),
      .rst_n       (rst_n),
      .restart     (restart),
      .run         (run),
      .sample_tick (sample_tick)
   );

   // Frame sequencing; outputs are registered and change only at the stop sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         shift_reg  <= '0;
         bit_cnt    <= '0;
         par_bad    <= 1'b0;
         data_frame <= '0;
         rx_done    <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (rx_fall) begin
                  state   <= ST_START;
                  bit_cnt <= '0;
                  par_bad <= 1'b0;
               end
            end
            ST_START: begin
               if (sample_tick) begin
                  // A high line at mid start bit was only a glitch.
                  state <= rx_s ? ST_IDLE : ST_DATA;
               end
            end
            ST_DATA: begin
               if (sample_tick) begin
                  shift_reg <= {rx_s, shift_reg[FRAME_WD-1:1]};
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt <= '0;
                     state   <= (PAR_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            ST_PARITY: begin
               if (sample_tick) begin
                  // Odd parity fails when the parity bit equals the data XOR.
                  par_bad <= (PAR_MODE == PAR_ODD) ? (rx_s == ^shift_reg)
                                                   : (rx_s != ^shift_reg);
                  state   <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (sample_tick) begin
                  frame_err  <= ~rx_s;
                  data_frame <= shift_reg;
                  parity_err <= (PAR_MODE != PAR_NONE) && par_bad;
                  rx_done    <= 1'b1;
                  // Back to idle mid stop bit so the next start edge is not missed.
                  state      <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: three receivers (NONE / EVEN / ODD parity) at
// BIT_DIV=10, driven by directed and random frames. Expected results are
// queued when a frame starts; a monitor pops them on every rx_done.
module tb_uart_frame_rx;

   typedef struct {
      int         ch;
      logic [7:0] data;
      logic       perr;
      logic       ferr;
      int         t_fall;
      int         lat;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [2:0] rx_line;
   logic [2:0] done;
   logic [2:0] perr;
   logic [2:0] ferr;
   logic [7:0] dframe [3];
   logic [2:0] prev_done;

   exp_t exp_q [$];
   exp_t e_mon;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   lat_act;

   uart_frame_rx #(.CLK_FREQUENCE(1_000_000), .BAUD_RATE(100_000),
                   .PARITY("NONE"), .FRAME_WD(8)) dut_none (
      .clk(clk), .rst_n(rst_n), .uart_rx(rx_line[0]), .data_frame(dframe[0]),
      .rx_done(done[0]), .parity_err(perr[0]), .frame_err(ferr[0]));

   uart_frame_rx #(.CLK_FREQUENCE(1_000_000), .BAUD_RATE(100_000),
                   .PARITY("EVEN"), .FRAME_WD(8)) dut_even (
      .clk(clk), .rst_n(rst_n), .uart_rx(rx_line[1]), .data_frame(dframe[1]),
      .rx_done(done[1]), .parity_err(perr[1]), .frame_err(ferr[1]));

   uart_frame_rx #(.CLK_FREQUENCE(1_000_000), .BAUD_RATE(100_000),
                   .PARITY("ODD"), .FRAME_WD(8)) dut_odd (
      .clk(clk), .rst_n(rst_n), .uart_rx(rx_line[2]), .data_frame(dframe[2]),
      .rx_done(done[2]), .parity_err(perr[2]), .frame_err(ferr[2]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int ch, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s ch%0d: got %0h expected %0h", name, ch, act, exp);
      end
   endtask

   // Monitor: every rx_done consumes one expected frame.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int c = 0; c < 3; c++) begin
            if (done[c]) begin
               chk("rx_done_single_cycle", c, 32'(prev_done[c]), 32'd0);
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_rx_done ch%0d: got strobe expected none at cycle %0d",
                           c, cyc);
               end else begin
                  e_mon = exp_q.pop_front();
                  chk("channel", c, 32'(c), 32'(e_mon.ch));
                  chk("data_frame", c, 32'(dframe[c]), 32'(e_mon.data));
                  chk("parity_err", c, 32'(perr[c]), 32'(e_mon.perr));
                  chk("frame_err", c, 32'(ferr[c]), 32'(e_mon.ferr));
                  lat_act = cyc - e_mon.t_fall;
                  n_cmp++;
                  if (lat_act < e_mon.lat - 1 || lat_act > e_mon.lat + 1) begin
                     n_bad++;
                     $display("FAIL latency ch%0d: got %0d expected %0d+-1",
                              c, lat_act, e_mon.lat);
                  end
               end
            end
         end
      end
      prev_done = done;
   end

   // Drives one frame starting now; caller is always #1 after a rising edge.
   task automatic send(input int ch, input logic [7:0] d, input logic par_bit,
                       input logic stop_bit, input logic exp_perr);
      exp_t e;
      e.ch     = ch;
      e.data   = d;
      e.perr   = exp_perr;
      e.ferr   = ~stop_bit;
      e.t_fall = cyc;
      e.lat    = (ch == 0) ? 98 : 108;
      exp_q.push_back(e);
      rx_line[ch] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (10) @(posedge clk);
         #1 rx_line[ch] = d[i];
      end
      if (ch != 0) begin
         repeat (10) @(posedge clk);
         #1 rx_line[ch] = par_bit;
      end
      repeat (10) @(posedge clk);
      #1 rx_line[ch] = stop_bit;
      repeat (10) @(posedge clk);
      #1 rx_line[ch] = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      end
   endtask

   initial begin
      logic [7:0] d;
      rst_n     = 1'b0;
      rx_line   = 3'b111;
      prev_done = 3'b000;
      repeat (3) @(posedge clk);
      #1;
      for (int c = 0; c < 3; c++) begin
         chk("reset_data_frame", c, 32'(dframe[c]), 32'd0);
         chk("reset_rx_done", c, 32'(done[c]), 32'd0);
         chk("reset_parity_err", c, 32'(perr[c]), 32'd0);
         chk("reset_frame_err", c, 32'(ferr[c]), 32'd0);
      end
      rst_n = 1'b1;
      idle(5);

      // No parity: 0xA5 clean
      send(0, 8'hA5, 1'b0, 1'b1, 1'b0);
      idle(5);
      // Even parity: 0x37 has five ones
      send(1, 8'h37, 1'b1, 1'b1, 1'b0);
      idle(5);
      send(1, 8'h37, 1'b0, 1'b1, 1'b1);
      idle(5);
      // Odd parity: 0x00 needs parity 1; 0xFF with parity 0 is even -> error
      send(2, 8'h00, 1'b1, 1'b1, 1'b0);
      idle(5);
      send(2, 8'hFF, 1'b0, 1'b1, 1'b1);
      idle(5);
      // Stop bit low, then a clean frame clears frame_err
      send(0, 8'h5A, 1'b0, 1'b0, 1'b0);
      idle(5);
      send(0, 8'h3C, 1'b0, 1'b1, 1'b0);
      idle(5);
      wait_drain();

      // Short low glitch must be rejected with outputs untouched
      rx_line[0] = 1'b0;
      idle(3);
      rx_line[0] = 1'b1;
      idle(150);
      chk("glitch_hold_data", 0, 32'(dframe[0]), 32'h3C);
      chk("glitch_hold_frame_err", 0, 32'(ferr[0]), 32'd0);

      // Back-to-back frames with a single stop bit between them
      send(0, 8'h01, 1'b0, 1'b1, 1'b0);
      send(0, 8'h80, 1'b0, 1'b1, 1'b0);
      idle(5);
      wait_drain();

      // Random frames on all three parity modes, correct parity
      for (int n = 0; n < 30; n++) begin
         for (int c = 0; c < 3; c++) begin
            d = 8'($urandom_range(255, 0));
            send(c, d, (c == 2) ? ~^d : ^d, 1'b1, 1'b0);
            idle(int'($urandom_range(3, 0)));
         end
      end
      idle(5);
      wait_drain();

      // Reset in the middle of a frame: outputs clear, no strobe afterwards
      rx_line[0] = 1'b0;
      idle(35);
      rst_n = 1'b0;
      rx_line[0] = 1'b1;
      #1;
      for (int c = 0; c < 3; c++) begin
         chk("midframe_reset_data", c, 32'(dframe[c]), 32'd0);
         chk("midframe_reset_flags", c, 32'({done[c], perr[c], ferr[c]}), 32'd0);
      end
      idle(3);
      rst_n = 1'b1;
      idle(150);
      chk("pending_frames_at_end", 0, 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
